reg_bank_ctrl: RTL and testbench

Parametrised successor to the single-port register controller. Provides a DEPTH-entry register bank on a simple sel/wr bus, with:
- byte-lane write strobes
- configurable read latency, with an explicit rvalid response
- an error response for out-of-range addresses

Sits between the bus decoder and peripheral control logic. It is a drop-in upgrade: with RD_LATENCY=1 and all strobes set, read/write timing matches the previous generation.

---
 rtl/reg_bank_pkg.sv | 17 +
 rtl/reg_bank_store.sv | 49 ++++
 rtl/reg_bank_ctrl.sv | 132 +++++++++++++
 tb/tb_reg_bank_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register bank controller.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int MAX_RD_LATENCY = 8;
    localparam int CNT_W = $clog2(MAX_RD_LATENCY);

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/reg_bank_store.sv
// Register storage: async reset, byte-strobe write port, combinational read port.
module reg_bank_store
    import reg_bank_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 200,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 32'h0000_1234
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [ADDR_WIDTH-1:0]               waddr,
    input  logic [DATA_WIDTH-1:0]               wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0]   wstrb,
    input  logic [ADDR_WIDTH-1:0]               raddr,
    output logic [DATA_WIDTH-1:0]               rdata
);

    localparam int SW = strb_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= RESET_VAL;
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == ADDR_WIDTH'(i)) begin
                    for (int k = 0; k < SW; k++) begin
                        if (wstrb[k])
                            mem[i][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    // Addresses with no backing entry read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_WIDTH'(i))
                rdata = mem[i];
        end
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register bank controller: sel/wr bus, byte strobes, configurable read
// latency with rvalid response and out-of-range error reporting.
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 200,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 32'h0000_1234,
    parameter int                    RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    err
);

    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_lat
        $fatal(1, "reg_bank_ctrl: RD_LATENCY must be 1..8");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_dw
        $fatal(1, "reg_bank_ctrl: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
        $fatal(1, "reg_bank_ctrl: DEPTH must be 1..2**ADDR_WIDTH");
    end

    localparam int                  LOAD    = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    state_t                  state;
    state_t                  state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nx;
    logic                    in_range;
    logic                    acc_wr;
    logic                    acc_rd;
    logic [DATA_WIDTH-1:0]   store_q;
    logic [DATA_WIDTH-1:0]   fresh;
    logic [DATA_WIDTH-1:0]   snap_data;
    logic                    snap_err;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    resp_err;

    // Extra top bit keeps the compare correct when DEPTH == 2**ADDR_WIDTH.
    assign in_range = {1'b0, addr} < DEPTH_W;
    assign ready    = (state == IDLE);
    assign acc_wr   = sel & ready & wr;
    assign acc_rd   = sel & ready & ~wr;
    assign fresh    = in_range ? store_q : '0;

    reg_bank_store #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .RESET_VAL  (RESET_VAL)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (acc_wr & in_range),
        .waddr (addr),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr (addr),
        .rdata (store_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (acc_rd) begin
                    cnt_nx   = CNT_W'(LOAD);
                    state_nx = (RD_LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == '0)
                    state_nx = RESP;
                else
                    cnt_nx = cnt - 1'b1;
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_data <= '0;
            snap_err  <= 1'b0;
        end else if (acc_rd) begin
            snap_data <= fresh;
            snap_err  <= ~in_range;
        end
    end

    // Single-cycle latency responds straight from the accept cycle.
    assign resp_data = (state == IDLE) ? fresh : snap_data;
    assign resp_err  = (state == IDLE) ? ~in_range : snap_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= (state_nx == RESP);
            rdata  <= (state_nx == RESP) ? resp_data : '0;
            err    <= ((state_nx == RESP) & resp_err) | (acc_wr & ~in_range);
        end
    end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Self-checking bench for reg_bank_ctrl: vector table, randomized traffic
// against an array model, and hand-written latency/reset corner cases.
module tb_reg_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;

    logic        rdy [3];
    logic        rv  [3];
    logic        er  [3];
    logic [31:0] rd  [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [256];

    always #5 clk = ~clk;

    reg_bank_ctrl #(.RD_LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .ready(rdy[0]), .rdata(rd[0]),
        .rvalid(rv[0]), .err(er[0])
    );

    reg_bank_ctrl #(.RD_LATENCY(4)) dut_l4 (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .ready(rdy[1]), .rdata(rd[1]),
        .rvalid(rv[1]), .err(er[1])
    );

    reg_bank_ctrl #(.RD_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .ready(rdy[2]), .rdata(rd[2]),
        .rvalid(rv[2]), .err(er[2])
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic void mdl_init();
        for (int i = 0; i < 256; i++)
            mdl[i] = (i < 200) ? 32'h0000_1234 : 32'h0;
    endfunction

    function automatic void mdl_write(input logic [7:0] a,
                                      input logic [31:0] d,
                                      input logic [3:0] s);
        if (a < 200)
            for (int k = 0; k < 4; k++)
                if (s[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
    endfunction

    // Starts and ends just after a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sel = 1'b0;
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_rvalid", 32'(rv[0]), 32'd0);
        chk("rst_rdata", rd[0], 32'h0);
        chk("rst_err", 32'(er[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mdl_init();
    endtask

    task automatic wr_op(input int d, input logic [7:0] a,
                         input logic [31:0] dat, input logic [3:0] s,
                         input logic exp_err);
        chk("wr_ready_before", 32'(rdy[d]), 32'd1);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = dat; wstrb = s;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0;
        chk("wr_err", 32'(er[d]), 32'(exp_err));
        chk("wr_ready_after", 32'(rdy[d]), 32'd1);
        chk("wr_rvalid", 32'(rv[d]), 32'd0);
    endtask

    task automatic rd_op(input int d, input int lat, input logic [7:0] a,
                         input logic [31:0] exp_d, input logic exp_err);
        chk("rd_ready_before", 32'(rdy[d]), 32'd1);
        sel = 1'b1; wr = 1'b0; addr = a;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            chk("rd_ready_low", 32'(rdy[d]), 32'd0);
            chk("rd_rvalid", 32'(rv[d]), 32'(k == lat));
            if (k == lat) begin
                chk("rd_rdata", rd[d], exp_d);
                chk("rd_err", 32'(er[d]), 32'(exp_err));
            end else begin
                chk("rd_rdata_idle", rd[d], 32'h0);
            end
            @(negedge clk);
        end
        chk("rd_ready_back", 32'(rdy[d]), 32'd1);
        chk("rd_rvalid_off", 32'(rv[d]), 32'd0);
    endtask

    initial begin
        vec_t        vt [12];
        logic [7:0]  a;
        logic [31:0] dv;
        logic [3:0]  sv;
        logic        seen;

        vt[0]  = '{1'b0, 8'h05, 32'h0,         4'h0, 32'h0000_1234, 1'b0};
        vt[1]  = '{1'b1, 8'h10, 32'hDEAD_BEEF, 4'h5, 32'h0,         1'b0};
        vt[2]  = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h00AD_12EF, 1'b0};
        vt[3]  = '{1'b1, 8'hF0, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        vt[4]  = '{1'b0, 8'hF0, 32'h0,         4'h0, 32'h0,         1'b1};
        vt[5]  = '{1'b1, 8'h10, 32'h5555_5555, 4'h0, 32'h0,         1'b0};
        vt[6]  = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h00AD_12EF, 1'b0};
        vt[7]  = '{1'b1, 8'hC7, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0};
        vt[8]  = '{1'b0, 8'hC7, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
        vt[9]  = '{1'b1, 8'hC8, 32'h1111_2222, 4'hF, 32'h0,         1'b1};
        vt[10] = '{1'b0, 8'hC8, 32'h0,         4'h0, 32'h0,         1'b1};
        vt[11] = '{1'b0, 8'hFF, 32'h0,         4'h0, 32'h0,         1'b1};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            if (vt[i].wr) begin
                wr_op(0, vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].exp_err);
                mdl_write(vt[i].addr, vt[i].wdata, vt[i].wstrb);
            end else begin
                rd_op(0, 2, vt[i].addr, vt[i].exp_rdata, vt[i].exp_err);
            end
        end

        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                dv = $urandom;
                sv = 4'($urandom_range(0, 15));
                wr_op(0, a, dv, sv, a >= 200);
                mdl_write(a, dv, sv);
            end else begin
                rd_op(0, 2, a, mdl[a], a >= 200);
            end
        end

        // Write held during ready=0 must be dropped.
        a = 8'h33;
        sel = 1'b1; wr = 1'b0; addr = a;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b1; wdata = 32'h0BAD_0BAD; wstrb = 4'hF;
        chk("t4_ready_low", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        sel = 1'b0;
        chk("t4_rvalid", 32'(rv[0]), 32'd1);
        chk("t4_rdata", rd[0], mdl[a]);
        chk("t4_err", 32'(er[0]), 32'd0);
        @(negedge clk);
        chk("t4_ready_after", 32'(rdy[0]), 32'd1);
        rd_op(0, 2, a, mdl[a], 1'b0);

        for (int i = 0; i < 256; i++)
            rd_op(0, 2, 8'(i), mdl[i], i >= 200);

        // Reset in the middle of a 4-cycle read.
        do_reset();
        wr_op(1, 8'h20, 32'hCAFE_F00D, 4'hF, 1'b0);
        sel = 1'b1; wr = 1'b0; addr = 8'h20;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0;
        chk("t5_busy", 32'(rdy[1]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rvalid_rst", 32'(rv[1]), 32'd0);
        chk("t5_ready_rst", 32'(rdy[1]), 32'd1);
        chk("t5_rdata_rst", rd[1], 32'h0);
        chk("t5_err_rst", 32'(er[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mdl_init();
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rv[1]) seen = 1'b1;
        end
        chk("t5_no_rvalid", 32'(seen), 32'd0);
        rd_op(1, 4, 8'h20, 32'h0000_1234, 1'b0);

        // Legacy single-cycle timing, back-to-back.
        do_reset();
        wr_op(2, 8'h01, 32'h0000_0001, 4'hF, 1'b0);
        rd_op(2, 1, 8'h01, 32'h0000_0001, 1'b0);
        wr_op(2, 8'h02, 32'h0000_0002, 4'hF, 1'b0);
        rd_op(2, 1, 8'h02, 32'h0000_0002, 1'b0);
        rd_op(2, 1, 8'hE0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
